// File: rtl/word_array.sv
// word_array: DEPTH x DATA_W storage, valid/ready requests, one-cycle read latency; an init FSM zeroes
// every word after reset or clr. Optional per-word even parity when WORD_ARRAY_PARITY_EN is defined.
module word_array #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] in_bus,
  input  logic              clr,
`ifdef WORD_ARRAY_PARITY_EN
  input  logic              par_inj,
  output logic              par_err,
`endif
  output logic              out_valid,
  output logic [DATA_W-1:0] out_bus,
  output logic              init_done
);

`ifdef WORD_ARRAY_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

  typedef enum logic {S_INIT, S_IDLE} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   init_ptr_q;
  logic                out_valid_q;
  logic [DATA_W-1:0]   out_bus_q;
  logic                par_err_q;
  logic [MEM_W-1:0]    mem [DEPTH];

  logic                accept;
  logic                in_range;
  logic                wr_en;
  logic [MEM_W-1:0]    rd_word;
  logic [MEM_W-1:0]    wr_word;

  assign req_ready = (state_q == S_IDLE) && !clr;
  assign init_done = (state_q == S_IDLE);
  assign accept    = req_valid && req_ready;
  // Non-power-of-2 depths leave a hole in the address space: writes there vanish, reads give 0.
  assign in_range  = ({1'b0, addr} < DEPTH_C);
  assign wr_en     = accept && rw && in_range;
  assign rd_word   = in_range ? mem[addr] : '0;

`ifdef WORD_ARRAY_PARITY_EN
  assign wr_word   = {(^in_bus) ^ par_inj, in_bus};
  assign par_err   = par_err_q;
`else
  assign wr_word   = in_bus;
`endif

  assign out_valid = out_valid_q;
  assign out_bus   = out_bus_q;

  // Storage has no reset; the init FSM owns clearing it.
  always_ff @(posedge clk) begin
    if (state_q == S_INIT) begin
      mem[init_ptr_q] <= '0;
    end else if (wr_en) begin
      mem[addr] <= wr_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_INIT;
      init_ptr_q  <= '0;
      out_valid_q <= 1'b0;
      out_bus_q   <= '0;
      par_err_q   <= 1'b0;
    end else begin
      out_valid_q <= accept && !rw;
      par_err_q   <= 1'b0;
      case (state_q)
        S_INIT: begin
          init_ptr_q <= init_ptr_q + ADDR_W'(1);
          if (init_ptr_q == LAST_C) begin
            state_q    <= S_IDLE;
            init_ptr_q <= '0;
          end
        end
        S_IDLE: begin
          if (clr) begin
            state_q    <= S_INIT;
            init_ptr_q <= '0;
          end
        end
        default: state_q <= S_INIT;
      endcase
      if (accept && !rw) begin
        out_bus_q <= rd_word[DATA_W-1:0];
        par_err_q <= in_range && ((^rd_word[DATA_W-1:0]) != rd_word[MEM_W-1]);
      end
    end
  end

endmodule
